mux_tree_pipe: RTL and testbench

Parametrised, pipelined N:1 multiplexer built as a binary tree of registered 2:1 stages. It carries a valid tag and the selected channel index alongside the data. A scan mode steps through all channels automatically. It is the next generation of the team's combinational 8:1 tree mux, for designs that need wide data, arbitrary power-of-two channel counts and timing closure at speed.

---
 rtl/mux_tree_pkg.sv | 16 +
 rtl/mux_tree_pipe_mux2_stage.sv | 32 +++
 rtl/mux_tree_pipe.sv | 79 +++++++
 tb/tb_mux_tree_pipe.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mux_tree_pkg.sv
// Shared constants and helpers for the pipelined N:1 tree multiplexer.
// Level count and channel-count legality are derived here.
package mux_tree_pkg;

   localparam int DEF_N_CH = 8;
   localparam int DEF_W    = 8;

   function automatic int tree_levels(input int n);
      return $clog2(n);
   endfunction

   function automatic bit n_ch_ok(input int n);
      return (n >= 2) && ((n & (n - 1)) == 0);
   endfunction

endpackage

// File: rtl/mux_tree_pipe_mux2_stage.sv
// One registered 2:1 mux node of the tree.
// Carries valid and the full channel index alongside the data.
module mux2_stage #(
   parameter int W     = 8,
   parameter int IDX_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid,
   input  logic [W-1:0]     a,
   input  logic [W-1:0]     b,
   input  logic             s,
   input  logic [IDX_W-1:0] idx,
   output logic             q_valid,
   output logic [W-1:0]     q,
   output logic [IDX_W-1:0] q_idx
);

   // pick a/b on s and register it with its tag; bubbles load too
   always_ff @(posedge clk) begin
      if (rst) begin
         q_valid <= 1'b0;
         q       <= '0;
         q_idx   <= '0;
      end else begin
         q_valid <= valid;
         q       <= s ? b : a;
         q_idx   <= idx;
      end
   end

endmodule

// File: rtl/mux_tree_pipe.sv
// Pipelined N:1 mux: binary heap of registered 2:1 nodes, LSB-first select.
// Scan mode steps through channels on each accepted sample.
module mux_tree_pipe
   import mux_tree_pkg::*;
#(
   parameter int N_CH  = DEF_N_CH,
   parameter int W     = DEF_W,
   parameter int SEL_W = $clog2(N_CH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [N_CH*W-1:0] din,
   input  logic [SEL_W-1:0]  sel,
   input  logic              mode,
   output logic              out_valid,
   output logic [W-1:0]      dout,
   output logic [SEL_W-1:0]  dout_ch
);

   localparam int L     = tree_levels(N_CH);
   localparam int NODES = 2 * N_CH - 1;

   if (!n_ch_ok(N_CH)) begin : g_bad_n_ch
      $error("mux_tree_pipe: N_CH must be a power of two >= 2");
   end

   // heap layout: node 0 is the root, leaves N_CH-1.. hold channels in order
   logic [W-1:0]     nd [NODES];
   logic             nv [NODES];
   logic [SEL_W-1:0] ni [NODES];

   logic [SEL_W-1:0] scan_cnt;
   logic [SEL_W-1:0] eff_sel;

   // scan counter: cleared outside scan mode, advances per accepted sample
   always_ff @(posedge clk) begin
      if (rst || !mode) begin
         scan_cnt <= '0;
      end else if (in_valid) begin
         scan_cnt <= scan_cnt + SEL_W'(1);
      end
   end

   assign eff_sel = mode ? scan_cnt : sel;

   for (genvar i = 0; i < N_CH; i++) begin : g_leaf
      assign nd[N_CH-1+i] = din[i*W +: W];
      assign nv[N_CH-1+i] = in_valid;
      assign ni[N_CH-1+i] = eff_sel;
   end

   // depth dd of the heap consumes select bit L-1-dd
   for (genvar dd = 0; dd < L; dd++) begin : g_lvl
      for (genvar m = 0; m < (1 << dd); m++) begin : g_node
         localparam int N = (1 << dd) - 1 + m;
         mux2_stage #(
            .W     (W),
            .IDX_W (SEL_W)
         ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .valid   (nv[2*N+1]),
            .a       (nd[2*N+1]),
            .b       (nd[2*N+2]),
            .s       (ni[2*N+1][L-1-dd]),
            .idx     (ni[2*N+1]),
            .q_valid (nv[N]),
            .q       (nd[N]),
            .q_idx   (ni[N])
         );
      end
   end

   assign out_valid = nv[0];
   assign dout      = nd[0];
   assign dout_ch   = ni[0];

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Scoreboard bench for mux_tree_pipe at N_CH=8/W=8, N_CH=2/W=1, N_CH=32/W=16.
// Expected outputs are queued when driven and checked L cycles later.
module tb_mux_tree_pipe;

   localparam int L8  = 3;
   localparam int L2  = 1;
   localparam int L32 = 5;

   typedef struct {
      bit          v;
      bit          z;
      logic [15:0] d;
      logic [4:0]  ch;
   } exp_t;

   int checks   = 0;
   int failures = 0;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic         v8 = 0, m8 = 0, ov8;
   logic [2:0]   sel8 = '0, ch8;
   logic [63:0]  din8 = '0;
   logic [7:0]   dout8;

   logic         v2 = 0, m2 = 0, ov2;
   logic [0:0]   sel2 = '0, ch2;
   logic [1:0]   din2 = '0;
   logic [0:0]   dout2;

   logic         v32 = 0, m32 = 0, ov32;
   logic [4:0]   sel32 = '0, ch32;
   logic [511:0] din32 = '0;
   logic [15:0]  dout32;

   // staged stimulus, applied by cycle()
   logic         s_rst = 1'b1;
   logic         s_v8 = 0, s_m8 = 0;
   logic [2:0]   s_sel8 = '0;
   logic [63:0]  s_din8 = '0;
   logic         s_v2 = 0, s_m2 = 0;
   logic [0:0]   s_sel2 = '0;
   logic [1:0]   s_din2 = '0;
   logic         s_v32 = 0, s_m32 = 0;
   logic [4:0]   s_sel32 = '0;
   logic [511:0] s_din32 = '0;

   exp_t q8[$], q2[$], q32[$];
   int cnt8 = 0, cnt2 = 0, cnt32 = 0;

   always #5 clk = ~clk;

   mux_tree_pipe #(.N_CH(8), .W(8)) u8 (
      .clk(clk), .rst(rst), .in_valid(v8), .din(din8), .sel(sel8),
      .mode(m8), .out_valid(ov8), .dout(dout8), .dout_ch(ch8)
   );

   mux_tree_pipe #(.N_CH(2), .W(1)) u2 (
      .clk(clk), .rst(rst), .in_valid(v2), .din(din2), .sel(sel2),
      .mode(m2), .out_valid(ov2), .dout(dout2), .dout_ch(ch2)
   );

   mux_tree_pipe #(.N_CH(32), .W(16)) u32 (
      .clk(clk), .rst(rst), .in_valid(v32), .din(din32), .sel(sel32),
      .mode(m32), .out_valid(ov32), .dout(dout32), .dout_ch(ch32)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input exp_t e, input logic ov,
                          input logic [15:0] d, input logic [4:0] c);
      chk({tag, "_valid"}, {31'd0, ov}, {31'd0, e.v});
      if (e.v || e.z) begin
         chk({tag, "_dout"}, {16'd0, d}, {16'd0, e.d});
         chk({tag, "_ch"}, {27'd0, c}, {27'd0, e.ch});
      end
   endtask

   task automatic cycle();
      exp_t e;
      int eff;
      @(negedge clk);
      if (q8.size() == L8) begin
         e = q8.pop_front();
         chk_out("n8", e, ov8, {8'd0, dout8}, {2'd0, ch8});
      end
      if (q2.size() == L2) begin
         e = q2.pop_front();
         chk_out("n2", e, ov2, {15'd0, dout2}, {4'd0, ch2});
      end
      if (q32.size() == L32) begin
         e = q32.pop_front();
         chk_out("n32", e, ov32, dout32, ch32);
      end
      rst = s_rst;
      v8 = s_v8; m8 = s_m8; sel8 = s_sel8; din8 = s_din8;
      v2 = s_v2; m2 = s_m2; sel2 = s_sel2; din2 = s_din2;
      v32 = s_v32; m32 = s_m32; sel32 = s_sel32; din32 = s_din32;

      eff = s_m8 ? cnt8 : int'(s_sel8);
      e.v = s_v8 && !s_rst; e.z = s_rst;
      e.d = s_rst ? 16'd0 : {8'd0, s_din8[eff*8 +: 8]};
      e.ch = s_rst ? 5'd0 : 5'(eff);
      if (s_rst || !s_m8) cnt8 = 0; else if (s_v8) cnt8 = (cnt8 + 1) % 8;
      if (s_rst) foreach (q8[i]) begin q8[i].v = 0; q8[i].z = 1; q8[i].d = 0; q8[i].ch = 0; end
      q8.push_back(e);

      eff = s_m2 ? cnt2 : int'(s_sel2);
      e.v = s_v2 && !s_rst; e.z = s_rst;
      e.d = s_rst ? 16'd0 : {15'd0, s_din2[eff]};
      e.ch = s_rst ? 5'd0 : 5'(eff);
      if (s_rst || !s_m2) cnt2 = 0; else if (s_v2) cnt2 = (cnt2 + 1) % 2;
      if (s_rst) foreach (q2[i]) begin q2[i].v = 0; q2[i].z = 1; q2[i].d = 0; q2[i].ch = 0; end
      q2.push_back(e);

      eff = s_m32 ? cnt32 : int'(s_sel32);
      e.v = s_v32 && !s_rst; e.z = s_rst;
      e.d = s_rst ? 16'd0 : s_din32[eff*16 +: 16];
      e.ch = s_rst ? 5'd0 : 5'(eff);
      if (s_rst || !s_m32) cnt32 = 0; else if (s_v32) cnt32 = (cnt32 + 1) % 32;
      if (s_rst) foreach (q32[i]) begin q32[i].v = 0; q32[i].z = 1; q32[i].d = 0; q32[i].ch = 0; end
      q32.push_back(e);
   endtask

   task automatic idle(input int n);
      s_v8 = 0; s_v2 = 0; s_v32 = 0; s_rst = 0;
      for (int i = 0; i < n; i++) cycle();
   endtask

   initial begin
      logic [2:0] seq [5];
      seq = '{3'd0, 3'd7, 3'd3, 3'd3, 3'd6};
      repeat (2) @(posedge clk);
      s_rst = 1;
      cycle();
      cycle();
      idle(3);

      // single pulse, sel=5
      for (int i = 0; i < 8; i++) s_din8[i*8 +: 8] = 8'(8'h10 + i);
      s_sel8 = 3'd5; s_v8 = 1;
      cycle();
      idle(5);

      // streaming select changes
      for (int i = 0; i < 5; i++) begin
         s_sel8 = seq[i]; s_v8 = 1; cycle();
      end
      idle(4);

      // scan: 10 contiguous samples
      s_m8 = 1;
      for (int i = 0; i < 10; i++) begin s_v8 = 1; cycle(); end
      // scan with gaps
      for (int i = 0; i < 8; i++) begin s_v8 = i[0]; cycle(); end
      // leave and re-enter scan
      s_m8 = 0; s_sel8 = 3'd2; s_v8 = 1; cycle(); cycle();
      s_m8 = 1;
      for (int i = 0; i < 3; i++) begin s_v8 = 1; cycle(); end
      idle(4);

      // reset mid-flight, fixed select
      s_m8 = 0;
      s_sel8 = 3'd1; s_v8 = 1; cycle();
      s_sel8 = 3'd2; cycle();
      s_sel8 = 3'd4; cycle();
      s_v8 = 0; s_rst = 1; cycle();
      idle(4);

      // reset with in_valid in scan mode: sample dropped, count restarts
      s_m8 = 1;
      for (int i = 0; i < 3; i++) begin s_v8 = 1; cycle(); end
      s_rst = 1; s_v8 = 1; cycle();
      s_rst = 0;
      for (int i = 0; i < 2; i++) begin s_v8 = 1; cycle(); end
      idle(4);

      // random sweep on all three
      for (int c = 0; c < 300; c++) begin
         s_v8 = $urandom_range(0, 1) == 1;
         s_m8 = $urandom_range(0, 3) == 0;
         s_sel8 = 3'($urandom);
         s_din8 = {$urandom, $urandom};
         s_v2 = $urandom_range(0, 1) == 1;
         s_m2 = $urandom_range(0, 3) == 0;
         s_sel2 = 1'($urandom);
         s_din2 = 2'($urandom);
         s_v32 = $urandom_range(0, 1) == 1;
         s_m32 = $urandom_range(0, 3) == 0;
         s_sel32 = 5'($urandom);
         for (int k = 0; k < 16; k++) s_din32[k*32 +: 32] = $urandom;
         cycle();
      end
      idle(L32 + 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
